// File: rtl/multi_lane_fifo.sv
// multi_lane_fifo: circular FIFO whose entries are WIDTH lanes of RES bits.
// Supports registered read (FWFT=0) or first-word-fall-through (FWFT=1).
// Ports:
//   clk, rst, clear       clock, sync active-high reset, sync flush (same effect)
//   wr_en, data_in        write request and entry (unpacked lane array)
//   rd_en                 read request
//   data_out, out_valid   read entry and its qualifier
//   empty/full/almost_*   status decoded from the registered count
//   count                 stored entries
//   overflow, underflow   sticky error flags, cleared only by rst/clear

// Storage and read path for one lane of every entry.
module multi_lane_fifo_lane #(
  parameter int RES   = 8,
  parameter int DEPTH = 4,
  parameter int PW    = 2,
  parameter int FWFT  = 0
) (
  input  logic           clk,
  input  logic           i_flush,
  input  logic           i_we,
  input  logic [PW-1:0]  i_waddr,
  input  logic [RES-1:0] i_din,
  input  logic           i_re,
  input  logic [PW-1:0]  i_raddr,
  output logic [RES-1:0] o_dout
);
  logic [RES-1:0] r_mem [DEPTH];

  // Memory is never reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_din;
  end

  if (FWFT != 0) begin : g_fwft
    logic w_unused;
    assign w_unused = &{1'b0, i_flush, i_re};
    assign o_dout   = r_mem[i_raddr];
  end else begin : g_reg
    logic [RES-1:0] r_dout;
    // Old contents are captured even when a write hits the same slot this
    // edge (full FIFO with simultaneous read and write).
    always_ff @(posedge clk) begin
      if (i_flush)   r_dout <= '0;
      else if (i_re) r_dout <= r_mem[i_raddr];
    end
    assign o_dout = r_dout;
  end
endmodule

module multi_lane_fifo #(
  parameter int RES      = 8,
  parameter int DEPTH    = 4,
  parameter int WIDTH    = 3,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [RES-1:0]             data_in [WIDTH],
  input  logic                       rd_en,
  output logic [RES-1:0]             data_out [WIDTH],
  output logic                       out_valid,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf, r_unf;
  logic          w_flush, w_rd_acc, w_wr_acc;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_flush  = rst | clear;
  // Flush wins over any request in the same cycle.
  assign w_rd_acc = ~w_flush & rd_en & ~empty;
  // A full FIFO still takes a write when a read frees a slot this cycle.
  assign w_wr_acc = ~w_flush & wr_en & (~full | w_rd_acc);

  assign count        = r_count;
  assign empty        = (r_count == '0);
  assign full         = (r_count == CW'(DEPTH));
  assign almost_full  = (r_count >= CW'(AF_LEVEL));
  assign almost_empty = (r_count <= CW'(AE_LEVEL));
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_rd_acc) r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (wr_en && !w_wr_acc) r_ovf <= 1'b1;
      if (rd_en && empty)     r_unf <= 1'b1;
    end
  end

  if (FWFT != 0) begin : g_vld_fwft
    assign out_valid = ~empty;
  end else begin : g_vld_reg
    logic r_out_valid;
    always_ff @(posedge clk) begin
      if (w_flush) r_out_valid <= 1'b0;
      else         r_out_valid <= w_rd_acc;
    end
    assign out_valid = r_out_valid;
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    multi_lane_fifo_lane #(
      .RES(RES), .DEPTH(DEPTH), .PW(PW), .FWFT(FWFT)
    ) u_lane (
      .clk     (clk),
      .i_flush (w_flush),
      .i_we    (w_wr_acc),
      .i_waddr (r_wr_ptr),
      .i_din   (data_in[g]),
      .i_re    (w_rd_acc),
      .i_raddr (r_rd_ptr),
      .o_dout  (data_out[g])
    );
  end
endmodule

// File: tb/tb_multi_lane_fifo.sv
// Bench for multi_lane_fifo: three instances (DEPTH=4 registered read,
// DEPTH=5 registered read, DEPTH=4 FWFT) share one stimulus stream and are
// each checked every cycle against a queue-based model.
module tb_multi_lane_fifo;
  localparam int RES = 8;
  localparam int W   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, clear, wr_en, rd_en;
  logic [W*RES-1:0] din_p;
  logic [RES-1:0] din [W];
  always_comb for (int i = 0; i < W; i++) din[i] = din_p[i*RES +: RES];

  logic [RES-1:0] dout0 [W], dout1 [W], dout2 [W];
  logic [2:0]     cnt [3];
  logic           o_v [3], emp [3], ful [3], af [3], ae [3], ovf [3], unf [3];
  logic [23:0]    dp [3];
  assign dp[0] = {dout0[2], dout0[1], dout0[0]};
  assign dp[1] = {dout1[2], dout1[1], dout1[0]};
  assign dp[2] = {dout2[2], dout2[1], dout2[0]};

  multi_lane_fifo #(.RES(RES), .DEPTH(4), .WIDTH(W), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .data_in(din),
    .rd_en(rd_en), .data_out(dout0), .out_valid(o_v[0]), .empty(emp[0]),
    .full(ful[0]), .almost_full(af[0]), .almost_empty(ae[0]), .count(cnt[0]),
    .overflow(ovf[0]), .underflow(unf[0]));
  multi_lane_fifo #(.RES(RES), .DEPTH(5), .WIDTH(W), .FWFT(0)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .data_in(din),
    .rd_en(rd_en), .data_out(dout1), .out_valid(o_v[1]), .empty(emp[1]),
    .full(ful[1]), .almost_full(af[1]), .almost_empty(ae[1]), .count(cnt[1]),
    .overflow(ovf[1]), .underflow(unf[1]));
  multi_lane_fifo #(.RES(RES), .DEPTH(4), .WIDTH(W), .FWFT(1)) dut2 (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .data_in(din),
    .rd_en(rd_en), .data_out(dout2), .out_valid(o_v[2]), .empty(emp[2]),
    .full(ful[2]), .almost_full(af[2]), .almost_empty(ae[2]), .count(cnt[2]),
    .overflow(ovf[2]), .underflow(unf[2]));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  function automatic int dep(input int k);
    return (k == 1) ? 5 : 4;
  endfunction

  task automatic cmp(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d got=%0h want=%0h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  // Model: a queue of entries per instance plus sticky flags and the
  // registered read result.
  logic [23:0] q [3][$];
  logic        m_ov [3], m_un [3], m_vld [3];
  logic [23:0] m_do [3];

  always @(posedge clk) begin : mdl
    int n;
    bit ra, wa;
    logic [23:0] p;
    for (int k = 0; k < 3; k++) begin
      if (rst || clear) begin
        q[k].delete();
        m_ov[k] = 1'b0; m_un[k] = 1'b0; m_vld[k] = 1'b0; m_do[k] = '0;
      end else begin
        n  = q[k].size();
        ra = rd_en && (n != 0);
        wa = wr_en && ((n != dep(k)) || ra);
        if (wr_en && !wa) m_ov[k] = 1'b1;
        if (rd_en && n == 0) m_un[k] = 1'b1;
        m_vld[k] = ra;
        if (ra) begin
          p = q[k].pop_front();
          if (k != 2) m_do[k] = p;
        end
        if (wa) q[k].push_back(din_p);
      end
    end
  end

  always @(negedge clk) begin : chk
    int n;
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        n = q[k].size();
        cmp("count", k, 32'(cnt[k]), n);
        cmp("empty", k, 32'(emp[k]), 32'(n == 0));
        cmp("full", k, 32'(ful[k]), 32'(n == dep(k)));
        cmp("almost_full", k, 32'(af[k]), 32'(n >= dep(k) - 1));
        cmp("almost_empty", k, 32'(ae[k]), 32'(n <= 1));
        cmp("overflow", k, 32'(ovf[k]), 32'(m_ov[k]));
        cmp("underflow", k, 32'(unf[k]), 32'(m_un[k]));
        if (k != 2) begin
          cmp("out_valid", k, 32'(o_v[k]), 32'(m_vld[k]));
          cmp("data_out", k, 32'(dp[k]), 32'(m_do[k]));
        end else begin
          cmp("out_valid", k, 32'(o_v[k]), 32'(n != 0));
          if (n != 0) cmp("data_out", k, 32'(dp[k]), 32'(q[k][0]));
        end
      end
    end
  end

  task automatic drive(input bit w, input bit r, input logic [23:0] e, input bit c);
    wr_en = w; rd_en = r; din_p = e; clear = c;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
  endtask

  localparam logic [23:0] E = 24'h332211;

  initial begin
    int wp, rp;
    rst = 1'b1; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din_p = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("rst_count", 0, 32'(cnt[0]), 0);
    cmp("rst_empty", 0, 32'(emp[0]), 1);
    cmp("rst_aempty", 0, 32'(ae[0]), 1);
    cmp("rst_dout", 0, 32'(dp[0]), 0);

    // Fill to full, then one write too many.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, E, 0);
      cmp("fill_count", 0, 32'(cnt[0]), i + 1);
    end
    cmp("full4", 0, 32'(ful[0]), 1);
    drive(1, 0, E, 0);
    cmp("ovf5", 0, 32'(ovf[0]), 1);
    cmp("cnt_stays4", 0, 32'(cnt[0]), 4);

    // Drain with a one-cycle out_valid pulse per read.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, '0, 0);
      cmp("rd_valid", 0, 32'(o_v[0]), 1);
      cmp("rd_data", 0, 32'(dp[0]), 32'(E));
      drive(0, 0, '0, 0);
      cmp("valid_drop", 0, 32'(o_v[0]), 0);
      cmp("data_hold", 0, 32'(dp[0]), 32'(E));
    end
    cmp("empty_after4", 0, 32'(emp[0]), 1);
    drive(0, 1, '0, 0);
    cmp("unf", 0, 32'(unf[0]), 1);

    // Simultaneous read/write while full, then from empty.
    drive(0, 0, '0, 1);
    cmp("clr_ovf", 0, 32'(ovf[0]), 0);
    cmp("clr_unf", 0, 32'(unf[0]), 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 24'($urandom), 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 24'($urandom), 0);
      cmp("full_wr_rd_cnt", 0, 32'(cnt[0]), 4);
      cmp("full_wr_rd_ovf", 0, 32'(ovf[0]), 0);
    end
    drive(0, 0, '0, 1);
    drive(1, 1, 24'h0BEEF0, 0);
    cmp("empty_wr_rd_cnt", 0, 32'(cnt[0]), 1);
    cmp("empty_wr_rd_unf", 0, 32'(unf[0]), 1);

    // FWFT single write shows without rd_en.
    drive(0, 0, '0, 1);
    drive(1, 0, 24'hA5A5A5, 0);
    cmp("fwft_data", 2, 32'(dp[2]), 32'h00A5A5A5);
    cmp("fwft_valid", 2, 32'(o_v[2]), 1);
    drive(0, 1, '0, 0);
    cmp("fwft_empty", 2, 32'(emp[2]), 1);

    // Clear while holding entries and with a write pending.
    drive(0, 1, '0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 24'($urandom), 0);
    cmp("pre_clr_cnt", 0, 32'(cnt[0]), 3);
    drive(1, 0, 24'h777777, 1);
    cmp("clr_cnt", 0, 32'(cnt[0]), 0);
    cmp("clr_empty", 0, 32'(emp[0]), 1);
    cmp("clr_flags", 0, 32'({ovf[0], unf[0]}), 0);
    drive(0, 0, '0, 0);
    cmp("clr_write_dropped", 0, 32'(cnt[0]), 0);

    // Random traffic with alternating bias, occasional clear and reset.
    for (int i = 0; i < 800; i++) begin
      wp = ((i / 100) % 2 == 0) ? 70 : 35;
      rp = ((i / 100) % 2 == 0) ? 35 : 70;
      rst = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
            24'($urandom), $urandom_range(0, 79) == 0);
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_lane_fifo.md
MULTI_LANE_FIFO -- requirements
Module: multi_lane_fifo

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter RES, default 8, SHALL set the bits per lane.
REQ-003 Parameter DEPTH, default 4, SHALL set the entries stored (any integer >= 2, not restricted to powers of two).
REQ-004 Parameter WIDTH, default 3, SHALL set the lanes per entry.
REQ-005 Parameter AF_LEVEL, default DEPTH-1, SHALL set the almost_full threshold (1..DEPTH).
REQ-006 Parameter AE_LEVEL, default 1, SHALL set the almost_empty threshold (0..DEPTH-1).
REQ-007 Parameter FWFT, default 0, SHALL select read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-008 Port list SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- clear  in  1  synchronous flush, same effect as rst on all state
- wr_en  in  1  write request
- data_in  in  WIDTH x RES (unpacked lane array)  write entry
- rd_en  in  1  read request
- data_out  out  WIDTH x RES  read entry
- out_valid  out  1  data_out qualifier
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  clog2(DEPTH+1)  stored entries
- overflow  out  1  sticky: write attempted while full and not accepted
- underflow  out  1  sticky: read attempted while empty

Function
REQ-009 A write SHALL be accepted iff wr_en && (!full || read accepted in the same cycle with FWFT=1, or with FWFT=0 and count==DEPTH).
REQ-010 A read SHALL be accepted iff rd_en && !empty.
REQ-011 Accepted write SHALL store all WIDTH lanes of data_in at wr_ptr; wr_ptr SHALL advance, wrapping from DEPTH-1 to 0.
REQ-012 Accepted read SHALL advance rd_ptr with the same wrap rule.
REQ-013 count SHALL go +1 on write only, -1 on read only, and stay unchanged on simultaneous accepted read and write.
REQ-014 empty, full, almost_full and almost_empty SHALL be decoded from the registered count and valid in the same cycle as count.
REQ-015 FWFT=0: data_out SHALL load mem[rd_ptr] on the edge that accepts a read; out_valid SHALL be 1 for exactly the following cycle; data_out SHALL otherwise hold.
REQ-016 FWFT=1: data_out SHALL show mem[rd_ptr] combinationally; out_valid SHALL equal !empty; rd_en SHALL pop the shown entry.
REQ-017 A simultaneous read and write when count==0 SHALL be resolved as: read rejected and underflow set, write accepted.
REQ-018 A simultaneous accepted read and write when full SHALL leave count==DEPTH and full==1; the written entry SHALL occupy the slot just freed.
REQ-019 overflow and underflow SHALL be set on the offending cycle and cleared only by rst or clear.
REQ-020 Write data SHALL never be corrupted by a rejected write; memory contents SHALL be untouched on rejection.

Reset
REQ-021 On rst or clear: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, out_valid=0, overflow=0, underflow=0, data_out=0 (FWFT=0). Memory contents need not be cleared.
REQ-022 rst or clear SHALL take priority over wr_en and rd_en in the same cycle; a mid-stream reset SHALL discard all stored entries.

Verification
REQ-023 Defaults, FWFT=0: write 0x11/0x22/0x33 lanes x4 -> count 1..4, full=1 after the 4th write; 5th write -> overflow=1, count stays 4.
REQ-024 Drain the above -> entries return in order, each one cycle after rd_en with a 1-cycle out_valid pulse; empty=1 after the 4th read; extra rd_en -> underflow=1.
REQ-025 DEPTH=5, 12 writes interleaved with reads -> pointers wrap at 4->0 and read order equals write order.
REQ-026 Full FIFO, simultaneous wr_en+rd_en for 3 cycles -> count stays DEPTH and no overflow; from empty, simultaneous wr_en+rd_en -> count 1 and underflow=1.
REQ-027 FWFT=1: a single write of 0xA5 -> data_out=0xA5 and out_valid=1 the next cycle with no rd_en; rd_en -> empty=1.
REQ-028 Assert clear while count=3 with wr_en=1 -> next cycle count=0, empty=1, both sticky flags 0, and the write is dropped.
